// File: rtl/basilisk_pkg.sv
`default_nettype none
// ============================================================================
// basilisk_pkg : shared constants and types for the Basilisk FP adder
// Rev 1.0
// ============================================================================
package basilisk_pkg;

  localparam int BASILISK_GRS_W = 3;

  localparam logic [2:0] RM_RNE = 3'd0;
  localparam logic [2:0] RM_RTZ = 3'd1;
  localparam logic [2:0] RM_RDN = 3'd2;
  localparam logic [2:0] RM_RUP = 3'd3;
  localparam logic [2:0] RM_RMM = 3'd4;

  localparam int BASILISK_SP_EXP_W = 8;
  localparam int BASILISK_SP_MAN_W = 23;
  localparam int BASILISK_SP_TAG_W = 4;

  typedef struct packed {
    logic                                            sign;
    logic                                            eff_sub;
    logic [BASILISK_SP_EXP_W-1:0]                    exp;
    logic [BASILISK_SP_MAN_W:0]                      big_man;
    logic [BASILISK_SP_MAN_W+BASILISK_GRS_W:0]       small_man;
    logic                                            special;
    logic [BASILISK_SP_EXP_W+BASILISK_SP_MAN_W:0]    special_val;
    logic                                            nv;
    logic [2:0]                                      mode;
    logic [BASILISK_SP_TAG_W-1:0]                    tag;
  } basilisk_add_align_result_t;

endpackage
`default_nettype wire

// File: rtl/basilisk_shift_sticky.sv
`default_nettype none
// ============================================================================
// basilisk_shift_sticky : saturating right shift, lost bits OR into bit 0
// Rev 1.0
// ============================================================================
module basilisk_shift_sticky #(
  parameter int WIDTH = 27,
  parameter int AMT_W = 8
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [AMT_W-1:0] amt_i,
  output logic [WIDTH-1:0] data_o
);

  logic [WIDTH-1:0] lost_mask;

  always_comb begin
    lost_mask = '0;
    data_o    = '0;
    if (32'(amt_i) >= 32'(WIDTH)) begin
      data_o = {{(WIDTH-1){1'b0}}, |data_i};
    end else begin
      lost_mask = ~({WIDTH{1'b1}} << amt_i);
      data_o    = data_i >> amt_i;
      data_o[0] = data_o[0] | (|(data_i & lost_mask));
    end
  end

endmodule
`default_nettype wire

// File: rtl/basilisk_add_align.sv
`default_nettype none
// ============================================================================
// basilisk_add_align : FP adder front end - compare/swap, align, specials
// Rev 1.0
// ============================================================================
module basilisk_add_align
  import basilisk_pkg::*;
#(
  parameter int EXP_W   = 8,
  parameter int MAN_W   = 23,
  parameter int LATENCY = 2,
  parameter int TAG_W   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_sub,
  input  logic                       in_a_sign,
  input  logic                       in_b_sign,
  input  logic [EXP_W-1:0]           in_a_exp,
  input  logic [EXP_W-1:0]           in_b_exp,
  input  logic [MAN_W-1:0]           in_a_man,
  input  logic [MAN_W-1:0]           in_b_man,
  input  logic                       in_a_nan,
  input  logic                       in_a_snan,
  input  logic                       in_a_inf,
  input  logic                       in_b_nan,
  input  logic                       in_b_snan,
  input  logic                       in_b_inf,
  input  logic [2:0]                 in_mode,
  input  logic [TAG_W-1:0]           in_tag,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_sign,
  output logic                       out_eff_sub,
  output logic [EXP_W-1:0]           out_exp,
  output logic [MAN_W:0]             out_big_man,
  output logic [MAN_W+3:0]           out_small_man,
  output logic                       out_special,
  output logic [EXP_W+MAN_W:0]       out_special_val,
  output logic                       out_nv,
  output logic [2:0]                 out_mode,
  output logic [TAG_W-1:0]           out_tag
);

  localparam int SIG_W = MAN_W + 1;
  localparam int ALN_W = SIG_W + BASILISK_GRS_W;
  localparam int VAL_W = 1 + EXP_W + MAN_W;
  localparam logic [EXP_W-1:0] EXP_ONE = {{(EXP_W-1){1'b0}}, 1'b1};
  localparam logic [VAL_W-1:0] QNAN    = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // Everything except the significand being aligned travels unchanged after stage 1.
  typedef struct packed {
    logic              sign;
    logic              eff_sub;
    logic [EXP_W-1:0]  exp;
    logic [SIG_W-1:0]  big;
    logic              special;
    logic [VAL_W-1:0]  sval;
    logic              nv;
    logic [2:0]        mode;
    logic [TAG_W-1:0]  tag;
  } info_t;

  logic             a_hid, b_hid, b_sign_eff, eff_sub, swap, tie;
  logic [EXP_W-1:0] a_eexp, b_eexp, small_eexp;
  info_t            s1_info_d;
  logic [SIG_W-1:0] s1_small_d;
  logic [EXP_W-1:0] s1_shamt_d;

  always_comb begin
    a_hid      = |in_a_exp;
    b_hid      = |in_b_exp;
    a_eexp     = a_hid ? in_a_exp : EXP_ONE;
    b_eexp     = b_hid ? in_b_exp : EXP_ONE;
    b_sign_eff = in_b_sign ^ in_sub;
    eff_sub    = in_a_sign ^ b_sign_eff;
    swap       = {in_b_exp, in_b_man} > {in_a_exp, in_a_man};
    tie        = {in_b_exp, in_b_man} == {in_a_exp, in_a_man};

    s1_info_d         = '0;
    s1_info_d.eff_sub = eff_sub;
    s1_info_d.sign    = (tie && eff_sub) ? (in_mode == RM_RDN)
                                         : (swap ? b_sign_eff : in_a_sign);
    s1_info_d.exp     = swap ? b_eexp : a_eexp;
    s1_info_d.big     = swap ? {b_hid, in_b_man} : {a_hid, in_a_man};
    s1_info_d.mode    = in_mode;
    s1_info_d.tag     = in_tag;
    small_eexp        = swap ? a_eexp : b_eexp;
    s1_small_d        = swap ? {a_hid, in_a_man} : {b_hid, in_b_man};
    s1_shamt_d        = s1_info_d.exp - small_eexp;

    if (in_a_nan || in_b_nan) begin
      s1_info_d.special = 1'b1;
      s1_info_d.sval    = QNAN;
      s1_info_d.nv      = in_a_snan | in_b_snan;
    end else if (in_a_inf && in_b_inf && eff_sub) begin
      s1_info_d.special = 1'b1;
      s1_info_d.sval    = QNAN;
      s1_info_d.nv      = 1'b1;
    end else if (in_a_inf) begin
      s1_info_d.special = 1'b1;
      s1_info_d.sval    = {in_a_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (in_b_inf) begin
      s1_info_d.special = 1'b1;
      s1_info_d.sval    = {b_sign_eff, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  // in_ready stays low until the first edge after reset is released.
  logic run_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) run_q <= 1'b0;
    else        run_q <= 1'b1;
  end

  logic             st1_ready;
  logic             out_v;
  info_t            out_info;
  logic [ALN_W-1:0] out_aligned;

  generate
    if (LATENCY == 1) begin : g_lat1
      logic             v_q;
      info_t            info_q;
      logic [ALN_W-1:0] aligned_q;
      logic [ALN_W-1:0] aligned_d;

      basilisk_shift_sticky #(.WIDTH(ALN_W), .AMT_W(EXP_W)) u_shift (
        .data_i ({s1_small_d, {BASILISK_GRS_W{1'b0}}}),
        .amt_i  (s1_shamt_d),
        .data_o (aligned_d)
      );

      assign st1_ready = !v_q || out_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v_q       <= 1'b0;
          info_q    <= '0;
          aligned_q <= '0;
        end else if (st1_ready) begin
          v_q       <= in_valid && run_q;
          info_q    <= s1_info_d;
          aligned_q <= aligned_d;
        end
      end

      assign out_v       = v_q;
      assign out_info    = info_q;
      assign out_aligned = aligned_q;
    end else begin : g_lat2
      logic             v1_q, v2_q;
      info_t            info1_q, info2_q;
      logic [SIG_W-1:0] small1_q;
      logic [EXP_W-1:0] shamt1_q;
      logic [ALN_W-1:0] aligned_d, aligned2_q;
      logic             st2_ready;

      basilisk_shift_sticky #(.WIDTH(ALN_W), .AMT_W(EXP_W)) u_shift (
        .data_i ({small1_q, {BASILISK_GRS_W{1'b0}}}),
        .amt_i  (shamt1_q),
        .data_o (aligned_d)
      );

      assign st2_ready = !v2_q || out_ready;
      assign st1_ready = !v1_q || st2_ready;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v1_q     <= 1'b0;
          info1_q  <= '0;
          small1_q <= '0;
          shamt1_q <= '0;
        end else if (st1_ready) begin
          v1_q     <= in_valid && run_q;
          info1_q  <= s1_info_d;
          small1_q <= s1_small_d;
          shamt1_q <= s1_shamt_d;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          v2_q       <= 1'b0;
          info2_q    <= '0;
          aligned2_q <= '0;
        end else if (st2_ready) begin
          v2_q       <= v1_q;
          info2_q    <= info1_q;
          aligned2_q <= aligned_d;
        end
      end

      assign out_v       = v2_q;
      assign out_info    = info2_q;
      assign out_aligned = aligned2_q;
    end
  endgenerate

  assign in_ready        = run_q && st1_ready;
  assign out_valid       = out_v;
  assign out_sign        = out_info.sign;
  assign out_eff_sub     = out_info.eff_sub;
  assign out_exp         = out_info.exp;
  assign out_big_man     = out_info.big;
  assign out_small_man   = out_aligned;
  assign out_special     = out_info.special;
  assign out_special_val = out_info.sval;
  assign out_nv          = out_info.nv;
  assign out_mode        = out_info.mode;
  assign out_tag         = out_info.tag;

endmodule
`default_nettype wire

// File: tb/tb_basilisk_add_align.sv
`default_nettype none
// ============================================================================
// tb_basilisk_add_align : vector table, flow-control sequences, random vs model
// Rev 1.0
// ============================================================================
module tb_basilisk_add_align;
  import basilisk_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready, in_sub;
  logic        in_a_sign, in_b_sign;
  logic [7:0]  in_a_exp, in_b_exp;
  logic [22:0] in_a_man, in_b_man;
  logic        in_a_nan, in_a_snan, in_a_inf, in_b_nan, in_b_snan, in_b_inf;
  logic [2:0]  in_mode;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready, out_sign, out_eff_sub;
  logic [7:0]  out_exp;
  logic [23:0] out_big_man;
  logic [26:0] out_small_man;
  logic        out_special;
  logic [31:0] out_special_val;
  logic        out_nv;
  logic [2:0]  out_mode;
  logic [3:0]  out_tag;

  always #5 clk = ~clk;

  basilisk_add_align #(.EXP_W(8), .MAN_W(23), .LATENCY(2), .TAG_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_sub(in_sub),
    .in_a_sign(in_a_sign), .in_b_sign(in_b_sign),
    .in_a_exp(in_a_exp), .in_b_exp(in_b_exp),
    .in_a_man(in_a_man), .in_b_man(in_b_man),
    .in_a_nan(in_a_nan), .in_a_snan(in_a_snan), .in_a_inf(in_a_inf),
    .in_b_nan(in_b_nan), .in_b_snan(in_b_snan), .in_b_inf(in_b_inf),
    .in_mode(in_mode), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sign(out_sign), .out_eff_sub(out_eff_sub), .out_exp(out_exp),
    .out_big_man(out_big_man), .out_small_man(out_small_man),
    .out_special(out_special), .out_special_val(out_special_val),
    .out_nv(out_nv), .out_mode(out_mode), .out_tag(out_tag)
  );

  typedef basilisk_add_align_result_t res_t;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        sub;
    logic [2:0]  mode;
    res_t        exp;
  } vec_t;

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  task automatic chk_res(input string nm, input res_t act, input res_t req);
    chk({nm, ".special"}, 64'(act.special), 64'(req.special));
    chk({nm, ".tag"},     64'(act.tag),     64'(req.tag));
    chk({nm, ".mode"},    64'(act.mode),    64'(req.mode));
    chk({nm, ".nv"},      64'(act.nv),      64'(req.nv));
    if (req.special) begin
      chk({nm, ".val"}, 64'(act.special_val), 64'(req.special_val));
    end else begin
      chk({nm, ".sign"},  64'(act.sign),      64'(req.sign));
      chk({nm, ".eff"},   64'(act.eff_sub),   64'(req.eff_sub));
      chk({nm, ".exp"},   64'(act.exp),       64'(req.exp));
      chk({nm, ".big"},   64'(act.big_man),   64'(req.big_man));
      chk({nm, ".small"}, 64'(act.small_man), 64'(req.small_man));
    end
  endtask

  function automatic res_t grab();
    res_t r;
    r.sign = out_sign;        r.eff_sub = out_eff_sub;   r.exp = out_exp;
    r.big_man = out_big_man;  r.small_man = out_small_man;
    r.special = out_special;  r.special_val = out_special_val;
    r.nv = out_nv;            r.mode = out_mode;         r.tag = out_tag;
    return r;
  endfunction

  task automatic drive_cmd(input logic [31:0] a, input logic [31:0] b, input logic sub,
                           input logic [2:0] mode, input logic [3:0] tag);
    in_a_sign = a[31]; in_a_exp = a[30:23]; in_a_man = a[22:0];
    in_b_sign = b[31]; in_b_exp = b[30:23]; in_b_man = b[22:0];
    in_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'd0);
    in_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'd0);
    in_a_snan = in_a_nan && !a[22];
    in_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'd0);
    in_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'd0);
    in_b_snan = in_b_nan && !b[22];
    in_sub = sub; in_mode = mode; in_tag = tag;
  endtask

  // Reference: magnitudes as integers, alignment as division/remainder.
  function automatic res_t model(input logic [31:0] a, input logic [31:0] b, input logic sub,
                                 input logic [2:0] mode, input logic [3:0] tag);
    res_t r;
    int unsigned ae, be, ea, eb, sa, sb, mag_a, mag_b, d, ext, pw;
    bit a_nan, a_snan, a_inf, b_nan, b_snan, b_inf, bs, eff, b_big;
    r = '0; r.mode = mode; r.tag = tag;
    ae = 32'(a[30:23]); be = 32'(b[30:23]);
    a_nan = (ae == 255) && (a[22:0] != 0); a_snan = a_nan && !a[22]; a_inf = (ae == 255) && (a[22:0] == 0);
    b_nan = (be == 255) && (b[22:0] != 0); b_snan = b_nan && !b[22]; b_inf = (be == 255) && (b[22:0] == 0);
    bs = b[31] ^ sub; eff = a[31] ^ bs;
    mag_a = 32'(a[30:0]); mag_b = 32'(b[30:0]);
    b_big = mag_b > mag_a;
    ea = (ae == 0) ? 1 : ae;  eb = (be == 0) ? 1 : be;
    sa = ((ae == 0) ? 0 : 32'h800000) + 32'(a[22:0]);
    sb = ((be == 0) ? 0 : 32'h800000) + 32'(b[22:0]);
    r.eff_sub = eff;
    if (mag_a == mag_b && eff) r.sign = (mode == RM_RDN);
    else                       r.sign = b_big ? bs : a[31];
    r.exp     = 8'(b_big ? eb : ea);
    r.big_man = 24'(b_big ? sb : sa);
    d   = b_big ? eb - ea : ea - eb;
    ext = (b_big ? sa : sb) * 8;
    if (d >= 27) r.small_man = 27'(ext != 0);
    else begin
      pw = 32'd1 << d;
      r.small_man = 27'(ext / pw) | 27'((ext % pw) != 0);
    end
    if (a_nan || b_nan) begin
      r.special = 1; r.special_val = 32'h7FC00000; r.nv = a_snan | b_snan;
    end else if (a_inf && b_inf && eff) begin
      r.special = 1; r.special_val = 32'h7FC00000; r.nv = 1;
    end else if (a_inf) begin
      r.special = 1; r.special_val = {a[31], 31'h7F800000};
    end else if (b_inf) begin
      r.special = 1; r.special_val = {bs, 31'h7F800000};
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    logic [31:0] v;
    v[31] = 1'($urandom_range(0, 1));
    v[22:0] = 23'($urandom);
    case ($urandom_range(0, 19))
      0:       begin v[30:23] = 8'hFF; v[22:0] = '0; end
      1:       begin v[30:23] = 8'hFF; v[0] = 1'b1; end
      2:       begin v[30:23] = 8'h00; v[22:0] = '0; end
      3:       v[30:23] = 8'h00;
      default: v[30:23] = 8'($urandom_range(100, 150));
    endcase
    return v;
  endfunction

  localparam int NV = 11;
  vec_t vecs[NV];
  res_t qsb[$];
  logic [3:0] got[$];

  initial begin
    res_t e, r;
    int   k, lat, nxt, recv, sent, seen;
    logic [31:0] ca, cb;
    logic        cs;
    logic [2:0]  cm;
    bit          acc;

    // {sign,eff,exp,big,small,special,val,nv,mode,tag}
    vecs[0]  = '{32'h3F800000, 32'h3F800000, 1'b0, RM_RNE, '{1'b0,1'b0,8'd127,24'h800000,27'h4000000,1'b0,32'h0,1'b0,3'd0,4'd0}};
    vecs[1]  = '{32'h3F800000, 32'hC0800000, 1'b0, RM_RNE, '{1'b1,1'b1,8'd129,24'h800000,27'h1000000,1'b0,32'h0,1'b0,3'd0,4'd0}};
    vecs[2]  = '{32'h3F800000, 32'h30800000, 1'b0, RM_RNE, '{1'b0,1'b0,8'd127,24'h800000,27'h0000001,1'b0,32'h0,1'b0,3'd0,4'd0}};
    vecs[3]  = '{32'h7F800000, 32'h7F800000, 1'b1, RM_RNE, '{1'b0,1'b0,8'd0,24'h0,27'h0,1'b1,32'h7FC00000,1'b1,3'd0,4'd0}};
    vecs[4]  = '{32'h7F800001, 32'h3F800000, 1'b0, RM_RNE, '{1'b0,1'b0,8'd0,24'h0,27'h0,1'b1,32'h7FC00000,1'b1,3'd0,4'd0}};
    vecs[5]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, RM_RDN, '{1'b1,1'b1,8'd127,24'hC00000,27'h6000000,1'b0,32'h0,1'b0,3'd0,4'd0}};
    vecs[6]  = '{32'h3FC00000, 32'h3FC00000, 1'b1, RM_RNE, '{1'b0,1'b1,8'd127,24'hC00000,27'h6000000,1'b0,32'h0,1'b0,3'd0,4'd0}};
    vecs[7]  = '{32'h7F800000, 32'h3F800000, 1'b0, RM_RUP, '{1'b0,1'b0,8'd0,24'h0,27'h0,1'b1,32'h7F800000,1'b0,3'd0,4'd0}};
    vecs[8]  = '{32'h3F800000, 32'h7F800000, 1'b1, RM_RTZ, '{1'b0,1'b0,8'd0,24'h0,27'h0,1'b1,32'hFF800000,1'b0,3'd0,4'd0}};
    vecs[9]  = '{32'h7FC00000, 32'h3F800000, 1'b0, RM_RMM, '{1'b0,1'b0,8'd0,24'h0,27'h0,1'b1,32'h7FC00000,1'b0,3'd0,4'd0}};
    vecs[10] = '{32'h00000001, 32'h00800000, 1'b0, RM_RNE, '{1'b0,1'b0,8'd1,24'h800000,27'h0000008,1'b0,32'h0,1'b0,3'd0,4'd0}};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive_cmd(32'h0, 32'h0, 1'b0, 3'd0, 4'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst.out_valid", 64'(out_valid), 64'd0);
    chk("rst.in_ready",  64'(in_ready),  64'd0);
    chk("rst.out_exp",   64'(out_exp),   64'd0);
    chk("rst.out_small", 64'(out_small_man), 64'd0);
    rst_n = 1'b1;
    #1 chk("rel.in_ready_pre", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    chk("rel.in_ready_post", 64'(in_ready), 64'd1);

    // Directed vectors, one at a time with latency check.
    for (int i = 0; i < NV; i++) begin
      drive_cmd(vecs[i].a, vecs[i].b, vecs[i].sub, vecs[i].mode, 4'(i));
      in_valid = 1'b1;
      @(negedge clk);
      k = 0;
      while (!in_ready && k < 20) begin @(negedge clk); k++; end
      @(posedge clk); #1 in_valid = 1'b0;
      lat = 0;
      do begin @(negedge clk); lat++; end while (!out_valid && lat < 20);
      chk($sformatf("vec%0d.lat", i), 64'(lat), 64'd2);
      e = vecs[i].exp; e.tag = 4'(i); e.mode = vecs[i].mode;
      chk_res($sformatf("vec%0d", i), grab(), e);
      @(posedge clk); #1;
    end

    // Backpressure: four tagged commands, sink stalled for five cycles.
    nxt = 0; got.delete();
    for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
      in_valid = (nxt < 4);
      drive_cmd(32'h3F800000, 32'h3F800000, 1'b0, RM_RNE, 4'(nxt));
      out_ready = (cyc >= 5);
      @(negedge clk);
      if (cyc == 4) begin
        chk("bp.accepted", 64'(nxt), 64'd2);
        chk("bp.in_ready", 64'(in_ready), 64'd0);
        chk("bp.out_tag_held", 64'(out_tag), 64'd0);
      end
      if (in_valid && in_ready) nxt++;
      if (out_valid && out_ready) got.push_back(out_tag);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    chk("bp.count", 64'(got.size()), 64'd4);
    for (int i = 0; i < 4 && i < got.size(); i++)
      chk($sformatf("bp.order%0d", i), 64'(got[i]), 64'(i));

    // Reset in the middle of a stalled stream.
    out_ready = 1'b0; in_valid = 1'b1;
    drive_cmd(32'h40000000, 32'h3F800000, 1'b0, RM_RNE, 4'd9);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("mid.out_valid", 64'(out_valid), 64'd0);
    chk("mid.in_ready",  64'(in_ready),  64'd0);
    in_valid = 1'b0;
    @(negedge clk); rst_n = 1'b1; out_ready = 1'b1;
    seen = 0;
    repeat (5) begin @(negedge clk); if (out_valid) seen++; end
    chk("mid.no_partial", 64'(seen), 64'd0);

    // Random traffic against the model with random valid/ready.
    qsb.delete(); sent = 0; recv = 0;
    ca = 0; cb = 0; cs = 0; cm = 0;
    @(posedge clk); #1;
    for (int cyc = 0; cyc < 8000 && recv < 300; cyc++) begin
      if (!in_valid && sent < 300 && $urandom_range(0, 9) < 7) begin
        ca = rand_op();
        cb = ($urandom_range(0, 7) == 0) ? {1'($urandom_range(0, 1)), ca[30:0]} : rand_op();
        cs = 1'($urandom_range(0, 1));
        cm = 3'($urandom_range(0, 4));
        drive_cmd(ca, cb, cs, cm, 4'(sent));
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin qsb.push_back(model(ca, cb, cs, cm, 4'(sent))); sent++; end
      if (out_valid && out_ready) begin
        if (qsb.size() == 0) chk($sformatf("rnd%0d.unexpected", recv), 64'd1, 64'd0);
        else chk_res($sformatf("rnd%0d", recv), grab(), qsb.pop_front());
        recv++;
      end
      @(posedge clk); #1;
      if (acc) in_valid = 1'b0;
    end
    chk("rnd.received", 64'(recv), 64'd300);

    r = grab();
    if (r.tag === 4'hx) $display("note: tag unknown");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
